// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, alu_cmd and decoded-control definitions
//
// Purpose : constants and types shared by the decode stage and its helpers.
// Contents: 4-bit opcode constants, 3-bit alu_cmd encodings, ctrl_t
//           decoded-control struct and decode_op() opcode decoder.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU0 = 4'd1;   // first register-register ALU opcode
    localparam logic [3:0] OP_ALU7 = 4'd8;   // last register-register ALU opcode
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BEZ  = 4'd12;
    localparam logic [3:0] OP_BNEZ = 4'd13;
    localparam logic [3:0] OP_JMP  = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    // alu_cmd = opcode - 1 for the ALU group
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef struct packed {
        logic [2:0] alu_cmd;
        logic       writes_rd;   // instruction produces a register result
        logic       mem_rd;
        logic       mem_wr;
        logic       use_imm;     // op_b comes from the immediate
        logic       reads_rs1;
        logic       reads_rs2;
        logic       is_bez;
        logic       is_bnez;
        logic       is_jmp;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [3:0] opcode);
        ctrl_t c;
        c = '0;
        if (opcode >= OP_ALU0 && opcode <= OP_ALU7) begin
            c.alu_cmd   = 3'(opcode - OP_ALU0);
            c.writes_rd = 1'b1;
            c.reads_rs1 = 1'b1;
            c.reads_rs2 = 1'b1;
        end else begin
            case (opcode)
                OP_ADDI: begin
                    c.alu_cmd   = ALU_ADD;
                    c.writes_rd = 1'b1;
                    c.use_imm   = 1'b1;
                    c.reads_rs1 = 1'b1;
                end
                OP_LD: begin
                    c.alu_cmd   = ALU_ADD;
                    c.writes_rd = 1'b1;
                    c.mem_rd    = 1'b1;
                    c.use_imm   = 1'b1;
                    c.reads_rs1 = 1'b1;
                end
                OP_ST: begin
                    c.alu_cmd   = ALU_ADD;
                    c.mem_wr    = 1'b1;
                    c.use_imm   = 1'b1;
                    c.reads_rs1 = 1'b1;
                    c.reads_rs2 = 1'b1;
                end
                OP_BEZ: begin
                    c.is_bez    = 1'b1;
                    c.reads_rs1 = 1'b1;
                end
                OP_BNEZ: begin
                    c.is_bnez   = 1'b1;
                    c.reads_rs1 = 1'b1;
                end
                OP_JMP: begin
                    c.is_jmp    = 1'b1;
                end
                // OP_NOP and OP_RSVD decode to all-zero controls
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - MEM-stage writeback bypass mux for one source operand
//
// Purpose : selects forwarded MEM data over register-file data when the
//           bypass is enabled and targets the same register.
// Ports   : rs_addr  in  REG_AW  source register being read
//           rs_rdata in  DATA_W  register-file data for rs_addr
//           fwd_en   in  1       MEM-stage writeback valid
//           fwd_addr in  REG_AW  MEM-stage destination register
//           fwd_data in  DATA_W  MEM-stage writeback data
//           op_data  out DATA_W  resolved operand
module operand_bypass #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int EN_FWD = 1
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_rdata,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] op_data
);

    logic fwd_hit;

    assign fwd_hit = (EN_FWD != 0) && fwd_en && (fwd_addr == rs_addr);
    assign op_data = fwd_hit ? fwd_data : rs_rdata;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with bypass, hazard and branch redirect
//
// Purpose : decodes one instruction per cycle into registered execute-stage
//           controls, resolves operands through the MEM bypass, stalls on
//           load-use hazards and redirects fetch on taken branches.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/instr          fetch-side handshake
//           rs1_addr/rs2_addr out            register-file read addresses
//           rs1_rdata/rs2_rdata in           register-file read data
//           fwd_en/fwd_addr/fwd_data in      MEM-stage writeback bypass
//           ex_stall in                      execute stage back-pressure
//           branch_taken/branch_offset out   combinational redirect
//           out_valid, alu_cmd, op_a, op_b, rd_addr, wb_en, mem_rd,
//           mem_wr, st_data out              registered decoded instruction
module decode_stage #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 6,
    parameter int EN_FWD  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  rs1_addr,
    output logic [REG_AW-1:0]  rs2_addr,
    input  logic [DATA_W-1:0]  rs1_rdata,
    input  logic [DATA_W-1:0]  rs2_rdata,
    input  logic               fwd_en,
    input  logic [REG_AW-1:0]  fwd_addr,
    input  logic [DATA_W-1:0]  fwd_data,
    input  logic               ex_stall,
    output logic               branch_taken,
    output logic [DATA_W-1:0]  branch_offset,
    output logic               out_valid,
    output logic [2:0]         alu_cmd,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
    output logic [REG_AW-1:0]  rd_addr,
    output logic               wb_en,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [DATA_W-1:0]  st_data
);

    import cpu_pkg::*;

    localparam int EXT_W = DATA_W - IMM_W;

    // instruction fields
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;
    logic [IMM_W-1:0]  imm_f;
    logic [DATA_W-1:0] imm_ext;
    ctrl_t             ctrl;

    logic [DATA_W-1:0] rs1_op;
    logic [DATA_W-1:0] rs2_op;

    logic hazard_match;
    logic hazard;
    logic fire;
    logic branch_cond;

    // registered outputs
    logic              out_valid_q, out_valid_d;
    logic [2:0]        alu_cmd_q,   alu_cmd_d;
    logic [DATA_W-1:0] op_a_q,      op_a_d;
    logic [DATA_W-1:0] op_b_q,      op_b_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic              wb_en_q,     wb_en_d;
    logic              mem_rd_q,    mem_rd_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [DATA_W-1:0] st_data_q,   st_data_d;

    assign opcode  = instr[INSTR_W-1 -: 4];
    assign rd_f    = instr[4*REG_AW-1 -: REG_AW];
    assign rs1_f   = instr[3*REG_AW-1 -: REG_AW];
    assign rs2_f   = instr[2*REG_AW-1 -: REG_AW];
    assign imm_f   = instr[IMM_W-1:0];
    assign imm_ext = {{EXT_W{imm_f[IMM_W-1]}}, imm_f};
    assign ctrl    = decode_op(opcode);

    assign rs1_addr = rs1_f;
    assign rs2_addr = rs2_f;

    operand_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .EN_FWD (EN_FWD)
    ) u_bypass_rs1 (
        .rs_addr  (rs1_f),
        .rs_rdata (rs1_rdata),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .op_data  (rs1_op)
    );

    operand_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .EN_FWD (EN_FWD)
    ) u_bypass_rs2 (
        .rs_addr  (rs2_f),
        .rs_rdata (rs2_rdata),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .op_data  (rs2_op)
    );

    // A load sitting in the output register has no data until MEM, so the
    // bypass cannot cover a consumer arriving right behind it. Only source
    // fields the incoming opcode actually reads are compared.
    assign hazard_match = (ctrl.reads_rs1 && (rs1_f == rd_addr_q)) ||
                          (ctrl.reads_rs2 && (rs2_f == rd_addr_q));
    assign hazard       = in_valid && out_valid_q && mem_rd_q &&
                          (rd_addr_q != '0) && hazard_match;

    assign in_ready = !ex_stall && !hazard;
    assign fire     = in_valid && in_ready;

    assign branch_cond   = (ctrl.is_bez  && (rs1_op == '0)) ||
                           (ctrl.is_bnez && (rs1_op != '0)) ||
                           ctrl.is_jmp;
    assign branch_taken  = fire && branch_cond;
    assign branch_offset = imm_ext;

    always_comb begin
        // ex_stall holds everything
        out_valid_d = out_valid_q;
        alu_cmd_d   = alu_cmd_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_addr_d   = rd_addr_q;
        wb_en_d     = wb_en_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        st_data_d   = st_data_q;

        if (!ex_stall) begin
            if (fire && !branch_taken) begin
                out_valid_d = 1'b1;
                alu_cmd_d   = ctrl.alu_cmd;
                // unread operand slots are driven to zero so NOP/JMP-like
                // instructions leave no stale register data downstream
                op_a_d      = ctrl.reads_rs1 ? rs1_op : '0;
                op_b_d      = ctrl.use_imm   ? imm_ext :
                              ctrl.reads_rs2 ? rs2_op  : '0;
                rd_addr_d   = ctrl.writes_rd ? rd_f : '0;
                // loads always write back; ALU/ADDI suppress writes to r0
                wb_en_d     = ctrl.mem_rd ||
                              (ctrl.writes_rd && (rd_f != '0));
                mem_rd_d    = ctrl.mem_rd;
                mem_wr_d    = ctrl.mem_wr;
                st_data_d   = ctrl.mem_wr ? rs2_op : '0;
            end else begin
                // bubble: nothing fired, branch redirect, or load-use hazard
                out_valid_d = 1'b0;
                alu_cmd_d   = '0;
                op_a_d      = '0;
                op_b_d      = '0;
                rd_addr_d   = '0;
                wb_en_d     = 1'b0;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
                st_data_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_addr_q   <= '0;
            wb_en_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            st_data_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_addr_q   <= rd_addr_d;
            wb_en_q     <= wb_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            st_data_q   <= st_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_cmd   = alu_cmd_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rd_addr   = rd_addr_q;
    assign wb_en     = wb_en_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign st_data   = st_data_q;

endmodule
